// File: rtl/ctrl_blk_2.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_blk_2
// Description : Pops bytes from a FIFO, accumulates groups of four and
//               writes their average to a RAM at a descending address.
//               Optional macro CTRL_BLK_2_ROUND_EN selects round-to-nearest
//               averaging; when undefined the average is truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_blk_2 #(
  parameter int                ADDR_W     = 11,
  parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_data,
  output logic              rd_fifo,
  output logic              ram_wr_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data
);

  typedef enum logic [1:0] {
    ST_RD  = 2'd0,
    ST_CAP = 2'd1,
    ST_WR  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [9:0]        sum_q, sum_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;

  // Running sum including the byte presented this cycle.
  logic [9:0] w_sum_cap;
  logic [7:0] w_avg;

  assign w_sum_cap = sum_q + {2'b00, fifo_data};

`ifdef CTRL_BLK_2_ROUND_EN
  // Max sum 1020, +2 = 1022 still fits in 10 bits, so no overflow.
  assign w_avg = 8'((w_sum_cap + 10'd2) >> 2);
`else
  assign w_avg = 8'(w_sum_cap >> 2);
`endif

  // State and datapath registers; reset discards any partial packet at once.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= ST_RD;
      sum_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= START_ADDR;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next-state, datapath updates and strobes.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rd_fifo  = 1'b0;
    ram_wr_n = 1'b1;

    case (state_q)
      ST_RD: begin
        // Reset gating keeps the pop request low while reset is held.
        rd_fifo = ~fifo_empty & ~reset;
        if (!fifo_empty) begin
          state_d = ST_CAP;
        end
      end

      ST_CAP: begin
        sum_d = w_sum_cap;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          // Fourth byte: latch the average so it is stable for the write.
          data_d  = w_avg;
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end

      ST_WR: begin
        ram_wr_n = 1'b0;
        sum_d    = '0;
        cnt_d    = '0;
        addr_d   = (addr_q == '0) ? START_ADDR : addr_q - ADDR_W'(1);
        state_d  = ST_RD;
      end

      default: begin
        state_d = ST_RD;
      end
    endcase
  end

  assign ram_addr = addr_q;
  assign ram_data = data_q;

endmodule
`default_nettype wire

// File: doc/ctrl_blk_2.md
CTRL_BLK_2 -- requirements
Module: ctrl_blk_2

Interface
REQ-001 Parameter ADDR_W, default 11: RAM address width in bits.
REQ-002 Parameter START_ADDR, default all ones ({ADDR_W{1'b1}}): first RAM address written after reset.
REQ-003 clk_2  input  1: single block clock; all state updates on its rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 fifo_empty  input  1: high when the byte FIFO holds no data.
REQ-006 fifo_data  input  8: FIFO read data, valid the cycle after rd_fifo is sampled high.
REQ-007 rd_fifo  output  1: single-cycle pop request to the FIFO.
REQ-008 ram_wr_n  output  1: active-low RAM write strobe.
REQ-009 ram_addr  output  ADDR_W: RAM write address.
REQ-010 ram_data  output  8: RAM write data (average of 4 packet bytes).

Function
REQ-011 The block SHALL run a 3-state FSM: RD, CAP, WR.
REQ-012 In RD, rd_fifo SHALL equal !fifo_empty (combinational); if !fifo_empty, next state CAP, else stay in RD.
REQ-013 rd_fifo SHALL be low in CAP and WR; never high while fifo_empty is high.
REQ-014 In CAP, the block SHALL add fifo_data, zero-extended, to a 10-bit sum and increment a 2-bit byte counter.
REQ-015 CAP transitions: byte counter was 3 -> WR; otherwise -> RD.
REQ-016 On entry to WR, the block SHALL register ram_data = sum[9:2], using the sum that includes the 4th byte.
REQ-017 In WR, ram_wr_n SHALL be low for exactly one cycle, with ram_addr and ram_data stable for that whole cycle.
REQ-018 On leaving WR, the block SHALL:
- clear sum and byte counter to 0;
- decrement ram_addr by 1;
- go to RD.
REQ-019 Address wrap: decrementing from 0 SHALL produce START_ADDR.
REQ-020 Latency: ram_wr_n SHALL go low in the cycle immediately after the CAP cycle of the 4th byte.
REQ-021 Minimum spacing between packets SHALL be 9 cycles (4×RD/CAP + WR); the block SHALL never pop more than one byte per 2 cycles.
REQ-022 FIFO empty mid-packet: the block SHALL wait in RD holding sum and count; no byte is lost or duplicated.
REQ-023 ram_wr_n SHALL be high in all states other than WR.

Reset
REQ-024 While reset is high, the block SHALL hold:
- state = RD; sum = 0; byte counter = 0;
- ram_addr = START_ADDR; ram_data = 0;
- ram_wr_n = 1; rd_fifo = 0.
REQ-025 Reset asserted mid-packet or during WR SHALL discard the partial sum immediately, and the aborted write SHALL terminate asynchronously.
REQ-026 After reset deassertion, the first write SHALL go to START_ADDR.

Configuration
REQ-027 Macro CTRL_BLK_2_ROUND_EN controls the averaging mode:
- defined: ram_data = (sum + 2) >> 2, computed in 10 bits (max 1022 -> 255, no overflow);
- undefined: ram_data = sum[9:2] (truncation).

Verification
REQ-028 Reset, then FIFO bytes 10,20,30,40 always available -> one ram_wr_n low pulse, ram_addr=0x7FF, ram_data=25 (both modes).
REQ-029 Bytes 1,1,1,2 -> ram_data=1 without CTRL_BLK_2_ROUND_EN; ram_data=1 with it (sum 5+2=7 -> 1). Bytes 1,1,2,2 -> 1 truncated, 2 rounded.
REQ-030 Bytes 0xFF×4 -> ram_data=0xFF in both modes; sum never exceeds 1020.
REQ-031 fifo_empty high for 5 cycles after the 2nd byte, then bytes 3–4 -> rd_fifo low throughout the gap; single write with the correct average; exactly 4 rd_fifo pulses.
REQ-032 2049 consecutive packets -> addresses 0x7FF down to 0x000, then the 2049th write at 0x7FF.
REQ-033 Reset asserted after 3 bytes of a packet, then 4 new bytes 8,8,8,8 -> ram_data=8 at ram_addr=0x7FF; the pre-reset bytes do not contribute.
